// File: rtl/crc32_if.sv
`default_nettype none
// ============================================================================
// Module   : crc32_if
// Purpose  : Byte/state bus between a CRC-32 caller (master) and crc32 (slave).
// Revision : 1.0  initial release
// ============================================================================
interface crc32_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  crc_en;
    logic [DATA_WIDTH-1:0] i_byte;
    logic [31:0]           i_crc_state;
    logic [31:0]           o_crc_state;
    logic [31:0]           crc_out;

    modport master (
        output crc_en,
        output i_byte,
        output i_crc_state,
        input  o_crc_state,
        input  crc_out
    );

    modport slave (
        input  crc_en,
        input  i_byte,
        input  i_crc_state,
        output o_crc_state,
        output crc_out
    );
endinterface
`default_nettype wire

// File: rtl/crc32.sv
`default_nettype none
// ============================================================================
// Module   : crc32
// Purpose  : Byte-wide CRC-32 (IEEE 802.3) next-state network plus FCS register.
//            Define CRC32_LUT_EN to use an elaborated 256x32 table instead of
//            the unrolled shift/XOR network.
// Revision : 1.0  initial release
// ============================================================================
module crc32 #(
    parameter int          DATA_WIDTH = 8,
    parameter int          CRC_WIDTH  = 32,
    parameter logic [31:0] POLY       = 32'h04C11DB7
) (
    input  logic   clk,
    input  logic   reset_n,
    crc32_if.slave bus
);
    if (DATA_WIDTH != 8) begin : g_bad_data_width
        $error("crc32: DATA_WIDTH must be 8");
    end
    if (CRC_WIDTH != 32) begin : g_bad_crc_width
        $error("crc32: CRC_WIDTH must be 32");
    end

    function automatic logic [7:0] f_bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [31:0] f_bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Eight MSB-first division steps; the loop unrolls into a pure XOR network.
    function automatic logic [31:0] f_step8(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 8; i++) begin
            r = r[31] ? ({r[30:0], 1'b0} ^ POLY) : {r[30:0], 1'b0};
        end
        return r;
    endfunction

    logic [7:0]  w_idx;
    logic [31:0] w_tval;
    logic [31:0] w_next;
    logic [31:0] crc_out_d;
    logic [31:0] crc_out_q;

    // Ethernet sends bit 0 first, so the byte is mirrored into MSB-first form.
    assign w_idx = f_bitrev8(bus.i_byte[7:0]) ^ bus.i_crc_state[31:24];

`ifdef CRC32_LUT_EN
    typedef logic [255:0][31:0] lut_t;

    function automatic lut_t f_build_lut();
        lut_t t;
        for (int n = 0; n < 256; n++) t[n] = f_step8({8'(n), 24'h000000});
        return t;
    endfunction

    localparam lut_t c_LUT = f_build_lut();

    assign w_tval = c_LUT[w_idx];
`else
    assign w_tval = f_step8({w_idx, 24'h000000});
`endif

    assign w_next          = {bus.i_crc_state[23:0], 8'h00} ^ w_tval;
    assign bus.o_crc_state = w_next;

    always_comb begin
        crc_out_d = crc_out_q;
        if (bus.crc_en) begin
            crc_out_d = ~f_bitrev32(w_next);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_out_q <= 32'h00000000;
        end else begin
            crc_out_q <= crc_out_d;
        end
    end

    assign bus.crc_out = crc_out_q;
endmodule
`default_nettype wire

// File: tb/tb_crc32.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc32
// Purpose  : Self-checking bench for crc32 against a reflected software CRC-32.
// Revision : 1.0  initial release
// ============================================================================
module tb_crc32;
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec   = 0;
    int   n_miss  = 0;

    logic [31:0] ref_r;
    logic [31:0] fb_state;
    logic [31:0] tmp_state;
    logic [7:0]  tmp_byte;
    string       s_check = "123456789";

    crc32_if #(.DATA_WIDTH(8)) bus ();

    crc32 #(
        .DATA_WIDTH (8),
        .CRC_WIDTH  (32),
        .POLY       (32'h04C11DB7)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Textbook LSB-first CRC-32 register update (reflected polynomial).
    function automatic logic [31:0] ref_byte(input logic [31:0] r, input logic [7:0] b);
        logic [31:0] c;
        c = r ^ {24'h000000, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge; leaves just after the accepting edge.
    task automatic send(input logic [7:0] b, input bit first);
        if (first) begin
            fb_state = 32'hFFFFFFFF;
            ref_r    = 32'hFFFFFFFF;
        end
        bus.crc_en      = 1'b1;
        bus.i_byte      = b;
        bus.i_crc_state = fb_state;
        ref_r           = ref_byte(ref_r, b);
        #1 chk("o_crc_state", bus.o_crc_state, rev32(ref_r));
        fb_state = bus.o_crc_state;
        @(posedge clk);
        #1;
    endtask

    task automatic send_check_string();
        for (int i = 0; i < 9; i++) send(s_check[i], i == 0);
        bus.crc_en = 1'b0;
    endtask

    initial begin
        bus.crc_en      = 1'b0;
        bus.i_byte      = 8'h00;
        bus.i_crc_state = 32'h00000000;
        #2 chk("reset_crc_out", bus.crc_out, 32'h00000000);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single zero byte from the initial state
        bus.crc_en      = 1'b1;
        bus.i_byte      = 8'h00;
        bus.i_crc_state = 32'hFFFFFFFF;
        #1 chk("zero_byte_state", bus.o_crc_state, 32'h4E08BFB4);
        @(posedge clk);
        #1 chk("zero_byte_fcs", bus.crc_out, 32'hD202EF8D);

        send_check_string();
        chk("check_123456789", bus.crc_out, 32'hCBF43926);
        chk("check_model", bus.crc_out, ~ref_r);

        // Disabled cycles: crc_out frozen, next-state still combinational
        repeat (5) begin
            tmp_byte        = 8'($urandom);
            tmp_state       = $urandom;
            bus.i_byte      = tmp_byte;
            bus.i_crc_state = tmp_state;
            #1 chk("comb_when_disabled", bus.o_crc_state,
                   rev32(ref_byte(rev32(tmp_state), tmp_byte)));
            @(posedge clk);
            #1 chk("hold_disabled", bus.crc_out, 32'hCBF43926);
        end

        // Partial frame, then asynchronous reset between edges
        for (int i = 0; i < 4; i++) send(s_check[i], i == 0);
        chk("partial_fcs", bus.crc_out, ~ref_r);
        bus.crc_en = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("async_reset", bus.crc_out, 32'h00000000);
        @(negedge clk) reset_n = 1'b1;
        bus.i_byte      = 8'($urandom);
        bus.i_crc_state = $urandom;
        @(posedge clk);
        #1 chk("post_reset_hold", bus.crc_out, 32'h00000000);

        send_check_string();
        chk("rerun_123456789", bus.crc_out, 32'hCBF43926);

        // Back-to-back random frames
        for (int f = 0; f < 50; f++) begin
            int len;
            len = int'($urandom_range(1500, 64));
            for (int j = 0; j < len; j++) send(8'($urandom), j == 0);
            chk("frame_fcs", bus.crc_out, ~ref_r);
        end
        bus.crc_en = 1'b0;
        @(posedge clk);
        #1 chk("final_hold", bus.crc_out, ~ref_r);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/crc32.md
CRC32 -- requirements
Module: crc32

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width per update; any other value SHALL raise an elaboration error.
REQ-002 SHALL have parameter CRC_WIDTH, default 32, CRC/state width; fixed at 32.
REQ-003 SHALL have parameter POLY, default 32'h04C11DB7, generator polynomial, normal (MSB-first) form.
REQ-004 clk  input  1  single clock; all registers on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 crc_en  input  1  enable; high = i_byte is a valid frame byte this cycle.
REQ-007 i_byte  input  DATA_WIDTH  frame byte, Ethernet bit order (bit 0 first on wire).
REQ-008 i_crc_state  input  32  current running CRC state, held by the caller (FFFFFFFF at frame start).
REQ-009 o_crc_state  output  32  next running CRC state after absorbing i_byte.
REQ-010 crc_out  output  32  finished FCS value for the bytes absorbed so far.

Function
REQ-011 o_crc_state SHALL be purely combinational from i_crc_state and i_byte, independent of crc_en and reset_n.
REQ-012 o_crc_state SHALL equal {i_crc_state[23:0], 8'h00} XOR T[idx], with idx = bitrev8(i_byte) XOR i_crc_state[31:24].
REQ-013 T[n] SHALL be the 32-bit MSB-first remainder of (n << 24) under POLY after 8 shift/XOR steps, e.g. T[8'hFF] = 32'hB1F740B4.
REQ-014 The caller SHALL register o_crc_state into i_crc_state on each enabled byte; the block holds no running state of its own.
REQ-015 On a rising clk edge with crc_en=1, crc_out SHALL load ~bitrev32(o_crc_state); latency = 1 cycle after the edge that accepts the last byte.
REQ-016 With crc_en=0, crc_out SHALL hold its value regardless of i_byte or i_crc_state changes.
REQ-017 The result SHALL equal standard CRC-32 (IEEE 802.3): reflected in/out, init FFFFFFFF, xorout FFFFFFFF.
REQ-018 crc_out bit order: crc_out[7:0] is the first FCS byte to transmit.
REQ-019 Back-to-back frames SHALL need no idle cycles; the caller reloads i_crc_state with FFFFFFFF for the first byte of the new frame.

Reset
REQ-020 reset_n low SHALL clear crc_out to 32'h00000000 immediately, without waiting for clk.
REQ-021 Reset mid-frame SHALL abandon the partial result; after release, crc_out holds 0 until the next enabled byte.
REQ-022 Deassertion SHALL be synchronised by the caller; the first enabled edge after release SHALL update normally.

Configuration
REQ-023 Macro CRC32_LUT_EN defined: T SHALL be a 256x32 constant table built at elaboration by a function; no file load.
REQ-024 Macro CRC32_LUT_EN undefined: o_crc_state SHALL come from an 8-step unrolled bitwise shift/XOR network, with no table.
REQ-025 o_crc_state and crc_out SHALL be bit-identical with and without CRC32_LUT_EN.

Verification
REQ-026 Feed bytes of ASCII "123456789" with state fed back from FFFFFFFF -> crc_out = 32'hCBF43926 one cycle after the last byte.
REQ-027 i_crc_state=FFFFFFFF, i_byte=00 -> o_crc_state = 32'h4E08BFB4 combinationally; one enabled edge -> crc_out = 32'hD202EF8D.
REQ-028 Reset mid-frame: reset_n=0 while crc_out is nonzero -> crc_out = 0 before the next clk edge; then rerun REQ-026 -> CBF43926.
REQ-029 crc_en=0 for 5 cycles while i_byte toggles randomly -> crc_out unchanged.
REQ-030 Run 50 random frames of 64-1500 random bytes, back-to-back -> each crc_out matches a software CRC-32 model, both with and without CRC32_LUT_EN.
